// File: rtl/rs_pkt_arbiter.sv
// Round-robin packet arbiter feeding one RS encoder input from NUM_SRC byte streams.
// Grants whole PKT_LEN-byte packets, generates tlast, and counts encoder framing errors.
//
//   state | meaning
//   IDLE  | no packet in flight; arbitrate when sched_en and any source is valid
//   XFER  | zero-latency passthrough from grant_id until byte PKT_LEN handshakes
module rs_pkt_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int PKT_LEN = 229,
   parameter int ERR_W   = 16,
   localparam int ID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                 core_clk,
   input  logic                 rst_n,
   input  logic                 sched_en,
   input  logic [8*NUM_SRC-1:0] s_tdata,
   input  logic [NUM_SRC-1:0]   s_tvalid,
   output logic [NUM_SRC-1:0]   s_tready,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   input  logic                 enc_tlast_missing,
   input  logic                 enc_tlast_unexp,
   output logic                 grant_valid,
   output logic [ID_W-1:0]      grant_id,
   output logic                 pkt_done,
   output logic [ERR_W-1:0]     err_missing_cnt,
   output logic [ERR_W-1:0]     err_unexp_cnt
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   localparam logic [7:0] LAST_CNT = 8'(PKT_LEN);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [7:0]        byte_cnt_q, byte_cnt_d;
   logic              pkt_done_q, pkt_done_d;
   logic [ERR_W-1:0]  err_missing_q, err_missing_d;
   logic [ERR_W-1:0]  err_unexp_q, err_unexp_d;

   logic              found;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   cand;
   logic              handshake;

   // Scan starts one past the previous winner so every source gets a turn.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = ID_W'((int'(last_grant_q) + k) % NUM_SRC);
         if (!found && s_tvalid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      last_grant_d  = last_grant_q;
      byte_cnt_d    = byte_cnt_q;
      pkt_done_d    = 1'b0;
      m_axis_tdata  = 8'h00;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_tready      = '0;
      handshake     = 1'b0;
      case (state_q)
         IDLE: begin
            if (sched_en && found) begin
               state_d      = XFER;
               grant_id_d   = pick;
               last_grant_d = pick;
            end
         end
         XFER: begin
            m_axis_tdata         = s_tdata[8*grant_id_q +: 8];
            m_axis_tvalid        = s_tvalid[grant_id_q];
            s_tready[grant_id_q] = m_axis_tready;
            m_axis_tlast         = (byte_cnt_q == LAST_CNT) && m_axis_tvalid;
            handshake            = m_axis_tvalid && m_axis_tready;
            if (handshake) begin
               if (byte_cnt_q == LAST_CNT) begin
                  byte_cnt_d = 8'd1;
                  state_d    = IDLE;
                  pkt_done_d = 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_missing_d = err_missing_q;
      err_unexp_d   = err_unexp_q;
      if (enc_tlast_missing && !(&err_missing_q)) err_missing_d = err_missing_q + ERR_W'(1);
      if (enc_tlast_unexp && !(&err_unexp_q))     err_unexp_d   = err_unexp_q + ERR_W'(1);
   end

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_id_q    <= '0;
         last_grant_q  <= ID_W'(NUM_SRC - 1);
         byte_cnt_q    <= 8'd1;
         pkt_done_q    <= 1'b0;
         err_missing_q <= '0;
         err_unexp_q   <= '0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         last_grant_q  <= last_grant_d;
         byte_cnt_q    <= byte_cnt_d;
         pkt_done_q    <= pkt_done_d;
         err_missing_q <= err_missing_d;
         err_unexp_q   <= err_unexp_d;
      end
   end

   assign grant_valid     = (state_q == XFER);
   assign grant_id        = grant_id_q;
   assign pkt_done        = pkt_done_q;
   assign err_missing_cnt = err_missing_q;
   assign err_unexp_cnt   = err_unexp_q;

endmodule

// File: tb/tb_rs_pkt_arbiter.sv
// Bench for rs_pkt_arbiter: random traffic against a packet-level reference model,
// plus literal checks for the directed scenarios and a narrow-counter saturation instance.
module tb_rs_pkt_arbiter;

   localparam int NS   = 4;
   localparam int PL   = 229;
   localparam int EW   = 16;
   localparam int EMAX = (1 << EW) - 1;

   logic          core_clk = 1'b0;
   logic          rst_n;
   logic          sched_en;
   logic [8*NS-1:0] s_tdata;
   logic [NS-1:0] s_tvalid;
   logic [NS-1:0] s_tready;
   logic [7:0]    m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          enc_tlast_missing;
   logic          enc_tlast_unexp;
   logic          grant_valid;
   logic [1:0]    grant_id;
   logic          pkt_done;
   logic [EW-1:0] err_missing_cnt;
   logic [EW-1:0] err_unexp_cnt;

   logic          sat_miss, sat_unexp;
   logic [1:0]    sat_tready;
   logic [7:0]    sat_tdata;
   logic          sat_tvalid, sat_tlast, sat_gv, sat_gid, sat_done;
   logic [1:0]    sat_miss_cnt, sat_unexp_cnt;

   always #5 core_clk = ~core_clk;

   rs_pkt_arbiter #(.NUM_SRC(NS), .PKT_LEN(PL), .ERR_W(EW)) dut (
      .core_clk(core_clk), .rst_n(rst_n), .sched_en(sched_en),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .enc_tlast_missing(enc_tlast_missing), .enc_tlast_unexp(enc_tlast_unexp),
      .grant_valid(grant_valid), .grant_id(grant_id), .pkt_done(pkt_done),
      .err_missing_cnt(err_missing_cnt), .err_unexp_cnt(err_unexp_cnt)
   );

   rs_pkt_arbiter #(.NUM_SRC(2), .PKT_LEN(4), .ERR_W(2)) u_sat (
      .core_clk(core_clk), .rst_n(rst_n), .sched_en(1'b0),
      .s_tdata(16'h0000), .s_tvalid(2'b00), .s_tready(sat_tready),
      .m_axis_tdata(sat_tdata), .m_axis_tvalid(sat_tvalid),
      .m_axis_tready(1'b0), .m_axis_tlast(sat_tlast),
      .enc_tlast_missing(sat_miss), .enc_tlast_unexp(sat_unexp),
      .grant_valid(sat_gv), .grant_id(sat_gid), .pkt_done(sat_done),
      .err_missing_cnt(sat_miss_cnt), .err_unexp_cnt(sat_unexp_cnt)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the encoder and how many bytes of the packet have gone.
   int   m_owner, m_gid, m_last, m_cnt, m_miss, m_unexp;
   bit   m_done;
   int   m_grants[$];
   int   d_grants[$];
   logic [7:0] src_byte [NS];
   logic [NS-1:0] hs_vec;
   int   pkt_hs, last_pkt_len;
   logic [7:0] tlast_data;
   bit   done_seen, prev_gv;

   task automatic model_reset();
      m_owner = -1; m_gid = 0; m_last = NS - 1; m_cnt = 1;
      m_done = 0; m_miss = 0; m_unexp = 0;
   endtask

   initial begin
      logic          gv, e_tvalid, e_tlast, hs;
      logic [7:0]    e_tdata;
      logic [NS-1:0] e_tready;
      model_reset();
      pkt_hs = 0; last_pkt_len = 0; tlast_data = 0; done_seen = 0; prev_gv = 0;
      forever begin
         @(negedge core_clk);
         hs_vec = s_tvalid & s_tready;
         if (!rst_n) begin
            model_reset();
            pkt_hs = 0;
         end
         gv       = (m_owner >= 0);
         e_tvalid = gv ? s_tvalid[m_owner] : 1'b0;
         e_tdata  = gv ? s_tdata[8*m_owner +: 8] : 8'h00;
         e_tready = '0;
         if (gv) e_tready[m_owner] = m_axis_tready;
         e_tlast  = e_tvalid && (m_cnt == PL);
         chk("grant_valid", 32'(grant_valid), 32'(gv));
         chk("grant_id", 32'(grant_id), 32'(m_gid));
         chk("m_axis_tvalid", 32'(m_axis_tvalid), 32'(e_tvalid));
         chk("m_axis_tdata", 32'(m_axis_tdata), 32'(e_tdata));
         chk("s_tready", 32'(s_tready), 32'(e_tready));
         chk("m_axis_tlast", 32'(m_axis_tlast), 32'(e_tlast));
         chk("pkt_done", 32'(pkt_done), 32'(m_done));
         chk("err_missing_cnt", 32'(err_missing_cnt), 32'(m_miss));
         chk("err_unexp_cnt", 32'(err_unexp_cnt), 32'(m_unexp));

         if (grant_valid && !prev_gv) d_grants.push_back(int'(grant_id));
         prev_gv = grant_valid;
         if (pkt_done) done_seen = 1;
         if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tlast) begin
               last_pkt_len = pkt_hs + 1;
               tlast_data   = m_axis_tdata;
               pkt_hs       = 0;
            end else pkt_hs++;
         end

         if (rst_n) begin
            hs     = e_tvalid && m_axis_tready;
            m_done = hs && (m_cnt == PL);
            if (gv) begin
               if (hs) begin
                  if (m_cnt == PL) begin m_owner = -1; m_cnt = 1; end
                  else m_cnt++;
               end
            end else if (sched_en) begin
               for (int k = 1; k <= NS; k++) begin
                  int c;
                  c = (m_last + k) % NS;
                  if (m_owner < 0 && s_tvalid[c]) begin
                     m_owner = c; m_gid = c; m_last = c;
                     m_grants.push_back(c);
                  end
               end
            end
            if (enc_tlast_missing && m_miss < EMAX) m_miss++;
            if (enc_tlast_unexp && m_unexp < EMAX) m_unexp++;
         end
      end
   end

   task automatic tick();
      @(posedge core_clk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (hs_vec[i]) src_byte[i] = src_byte[i] + 8'd1;
         s_tdata[8*i +: 8] = src_byte[i];
      end
   endtask

   task automatic wait_done(input int lim, input string nm);
      int n;
      n = 0;
      done_seen = 0;
      while (!done_seen && n < lim) begin
         tick();
         n++;
      end
      if (!done_seen) chk(nm, 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_order[5];
      int n;
      exp_order = '{0, 1, 2, 3, 0};
      rst_n = 1'b0; sched_en = 1'b0; s_tvalid = '0; m_axis_tready = 1'b0;
      enc_tlast_missing = 1'b0; enc_tlast_unexp = 1'b0; sat_miss = 1'b0; sat_unexp = 1'b0;
      for (int i = 0; i < NS; i++) src_byte[i] = 8'h00;
      s_tdata = '0;
      tick(); tick(); tick();
      rst_n = 1'b1;

      // Source 0 alone: one full packet of bytes 0x00..0xE4
      m_grants.delete(); d_grants.delete();
      sched_en = 1'b1; s_tvalid = 4'b0001; m_axis_tready = 1'b1;
      wait_done(400, "p1_timeout");
      s_tvalid = '0;
      tick(); tick();
      chk("p1_first_grant", (d_grants.size() > 0) ? 32'(d_grants[0]) : 32'hFFFF, 32'd0);
      chk("p1_model_grant", (m_grants.size() > 0) ? 32'(m_grants[0]) : 32'hFFFF, 32'd0);
      chk("p1_pkt_len", 32'(last_pkt_len), 32'd229);
      chk("p1_tlast_data", 32'(tlast_data), 32'hE4);

      // Error pulses: missing for 3 cycles, unexpected once alongside
      do_reset();
      enc_tlast_missing = 1'b1; enc_tlast_unexp = 1'b1; sat_miss = 1'b1; sat_unexp = 1'b1;
      tick();
      enc_tlast_unexp = 1'b0; sat_unexp = 1'b0;
      tick(); tick();
      enc_tlast_missing = 1'b0;
      tick(); tick();
      sat_miss = 1'b0;
      tick();
      chk("err_missing_3", 32'(err_missing_cnt), 32'd3);
      chk("err_unexp_1", 32'(err_unexp_cnt), 32'd1);
      chk("sat_missing_5to3", 32'(sat_miss_cnt), 32'd3);
      chk("sat_unexp_1", 32'(sat_unexp_cnt), 32'd1);

      // All four sources continuously valid: round-robin from source 0
      do_reset();
      m_grants.delete(); d_grants.delete();
      s_tvalid = 4'hF; m_axis_tready = 1'b1; sched_en = 1'b1;
      for (int p = 0; p < 5; p++) wait_done(300, "p2_timeout");
      s_tvalid = '0;
      tick(); tick();
      chk("p2_dut_grants", 32'(d_grants.size() >= 5), 32'd1);
      chk("p2_model_grants", 32'(m_grants.size() >= 5), 32'd1);
      if (d_grants.size() >= 5 && m_grants.size() >= 5)
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("p2_dut_order%0d", i), 32'(d_grants[i]), 32'(exp_order[i]));
            chk($sformatf("p2_model_order%0d", i), 32'(m_grants[i]), 32'(exp_order[i]));
         end
      chk("p2_pkt_len", 32'(last_pkt_len), 32'd229);

      // Random traffic: stalls, source gaps, scheduler gating and error pulses
      for (int c = 0; c < 6000; c++) begin
         for (int i = 0; i < NS; i++) s_tvalid[i] = ($urandom_range(0, 9) != 0);
         m_axis_tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 49) == 0) sched_en = ~sched_en;
         enc_tlast_missing = ($urandom_range(0, 31) == 0);
         enc_tlast_unexp   = ($urandom_range(0, 31) == 0);
         tick();
      end
      enc_tlast_missing = 1'b0; enc_tlast_unexp = 1'b0;

      // Reset at byte 120 of a packet, then a clean packet must be 229 bytes
      s_tvalid = 4'hF; m_axis_tready = 1'b1; sched_en = 1'b1;
      n = 0;
      while (pkt_hs != 120 && n < 800) begin tick(); n++; end
      chk("p5_reach_120", 32'(pkt_hs), 32'd120);
      do_reset();
      chk("p5_gv_after_reset", 32'(grant_valid), 32'd0);
      wait_done(300, "p5_timeout");
      chk("p5_pkt_len", 32'(last_pkt_len), 32'd229);
      s_tvalid = '0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
